mem_port_arbiter: RTL and testbench

//   Shares one memory request/response port between 2**CTRL requesters
//   (e.g. icache/dcache refill paths). Uses round-robin arbitration.

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory request/response port among 2**CTRL
// requesters, with a single outstanding transaction and one-hot response routing.
module mem_port_arbiter #(
   parameter int CTRL       = 1,
   parameter int DATA_WIDTH = 32
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic [(1<<CTRL)-1:0]                req_i,
   input  logic [(1<<CTRL)*DATA_WIDTH-1:0]     req_data_i,
   output logic [(1<<CTRL)-1:0]                gnt_o,
   output logic                                mem_req_valid_o,
   output logic [DATA_WIDTH-1:0]               mem_req_data_o,
   input  logic                                mem_req_ready_i,
   input  logic                                mem_resp_valid_i,
   input  logic [DATA_WIDTH-1:0]               mem_resp_data_i,
   output logic [(1<<CTRL)-1:0]                resp_valid_o,
   output logic [(1<<CTRL)*DATA_WIDTH-1:0]     resp_data_o
);

   localparam int N = 1 << CTRL;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [CTRL-1:0]       ptr_q, ptr_d;
   logic [CTRL-1:0]       owner_q, owner_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   logic                  found;
   logic [CTRL-1:0]       pick;
   logic [CTRL-1:0]       idx;
   logic [N-1:0]          owner_onehot;
   logic                  resp_fire;

   // Scan ptr, ptr+1, ... ; the CTRL-bit index wraps modulo N on its own.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      found = 1'b0;
      pick  = ptr_q;
      idx   = ptr_q;
      for (int k = 0; k < N; k++) begin
         idx = ptr_q + CTRL'(k);
         if (!found && req_i[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               owner_d = pick;
               data_d  = req_data_i[pick*DATA_WIDTH +: DATA_WIDTH];
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (mem_req_ready_i) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_resp_valid_i) begin
               ptr_d   = owner_q + CTRL'(1);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset_i) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         data_q  <= data_d;
      end
   end

   assign owner_onehot    = N'(1) << owner_q;
   assign gnt_o           = (state_q != ST_IDLE) ? owner_onehot : '0;
   assign mem_req_valid_o = (state_q == ST_ISSUE);
   assign mem_req_data_o  = data_q;

   // The response path is combinational: the owner sees the pulse in the same cycle.
   assign resp_fire    = (state_q == ST_WAIT) && mem_resp_valid_i;
   assign resp_valid_o = resp_fire ? owner_onehot : '0;

   always_comb begin
      resp_data_o = '0;
      for (int i = 0; i < N; i++) begin
         if (resp_fire && (owner_q == CTRL'(i))) begin
            resp_data_o[i*DATA_WIDTH +: DATA_WIDTH] = mem_resp_data_i;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a scoreboard queue holds the expected
// owner/data of each response, popped by a negedge monitor when a pulse appears.
module tb_mem_port_arbiter;

   localparam int CTRL = 1;
   localparam int DW   = 32;
   localparam int N    = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    gnt;
   logic            mem_req_valid;
   logic [DW-1:0]   mem_req_data;
   logic            mem_req_ready;
   logic            mem_resp_valid;
   logic [DW-1:0]   mem_resp_data;
   logic [N-1:0]    resp_valid;
   logic [N*DW-1:0] resp_data;

   typedef struct {
      int            owner;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   mem_port_arbiter #(.CTRL(CTRL), .DATA_WIDTH(DW)) dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .req_i           (req),
      .req_data_i      (req_data),
      .gnt_o           (gnt),
      .mem_req_valid_o (mem_req_valid),
      .mem_req_data_o  (mem_req_data),
      .mem_req_ready_i (mem_req_ready),
      .mem_resp_valid_i(mem_resp_valid),
      .mem_resp_data_i (mem_resp_data),
      .resp_valid_o    (resp_valid),
      .resp_data_o     (resp_data)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N-1:0] oh(input int i);
      return N'(1) << i;
   endfunction

   // Response monitor: every pulse must match the oldest scoreboard entry.
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] want;
      if (resp_valid != '0) begin
         if (sb_q.size() == 0) begin
            check("unexpected_resp", 64'(resp_valid), 64'(0));
         end else begin
            e    = sb_q.pop_front();
            want = 64'(e.data) << (e.owner * DW);
            check("sb_route", 64'(resp_valid), 64'(oh(e.owner)));
            check("sb_data", resp_data, want);
         end
      end else begin
         check("resp_data_zero", resp_data, 64'(0));
      end
   end

   // Entered in an IDLE cycle with req already driven; returns in the IDLE cycle after the response.
   task automatic txn(input int owner, input logic [DW-1:0] payload, input logic [DW-1:0] rdata,
                      input int ready_wait, input int resp_wait, input bit drop_in_wait,
                      input bit stray_in_issue);
      int   n = 0;
      exp_t e;
      check("idle_no_valid", 64'(mem_req_valid), 64'(0));
      while (!mem_req_valid && n < 20) begin
         cyc();
         n++;
      end
      check("issue_latency", 64'(n), 64'(1));
      check("issue_gnt", 64'(gnt), 64'(oh(owner)));
      check("issue_payload", 64'(mem_req_data), 64'(payload));
      e.owner = owner;
      e.data  = rdata;
      sb_q.push_back(e);
      req_data = ~req_data;
      for (int i = 0; i < ready_wait; i++) begin
         mem_req_ready  = 1'b0;
         mem_resp_valid = stray_in_issue;
         mem_resp_data  = 32'hBAD0_0000 + DW'(i);
         cyc();
         check("bp_valid", 64'(mem_req_valid), 64'(1));
         check("bp_payload", 64'(mem_req_data), 64'(payload));
         check("bp_gnt", 64'(gnt), 64'(oh(owner)));
      end
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b0;
      cyc();
      mem_req_ready = 1'b0;
      if (drop_in_wait) req = '0;
      #1;
      check("wait_valid_low", 64'(mem_req_valid), 64'(0));
      check("wait_gnt", 64'(gnt), 64'(oh(owner)));
      for (int i = 0; i < resp_wait; i++) begin
         cyc();
         check("wait_hold_gnt", 64'(gnt), 64'(oh(owner)));
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = rdata;
      #1;
      check("resp_route", 64'(resp_valid), 64'(oh(owner)));
      cyc();
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      check("post_gnt", 64'(gnt), 64'(0));
      check("post_valid", 64'(mem_req_valid), 64'(0));
   endtask

   initial begin
      reset          = 1'b1;
      req            = '0;
      req_data       = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      repeat (3) cyc();
      check("rst_gnt", 64'(gnt), 64'(0));
      check("rst_req_valid", 64'(mem_req_valid), 64'(0));
      check("rst_req_data", 64'(mem_req_data), 64'(0));
      check("rst_resp_valid", 64'(resp_valid), 64'(0));
      check("rst_resp_data", resp_data, 64'(0));
      reset = 1'b0;

      // Single requester, ready in the issue cycle, response three cycles later.
      req      = 2'b01;
      req_data = {32'h5555_5555, 32'h0000_00A5};
      txn(0, 32'h0000_00A5, 32'h0000_1234, 0, 2, 1'b0, 1'b0);
      req = '0;

      // Contention from ptr=0: expect 0,1,0,1.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("rst2_gnt", 64'(gnt), 64'(0));
      req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         req_data = {32'h200 + DW'(k), 32'h100 + DW'(k)};
         txn(k % 2, (k % 2 == 1) ? 32'h200 + DW'(k) : 32'h100 + DW'(k),
             32'hD000 + DW'(k), 0, k, 1'b0, 1'b0);
      end
      req = '0;

      // Backpressure for 5 cycles with stray responses during ISSUE.
      req      = 2'b10;
      req_data = {32'h0000_3C3C, 32'h0000_0001};
      txn(1, 32'h0000_3C3C, 32'h0000_BEEF, 5, 1, 1'b0, 1'b1);
      req = '0;

      // Move ptr to 1, then requester 1 drops req in WAIT; ptr must advance to 0.
      req      = 2'b01;
      req_data = {32'h0000_0077, 32'h0000_0033};
      txn(0, 32'h0000_0033, 32'h0000_3333, 0, 0, 1'b0, 1'b0);
      req      = 2'b10;
      req_data = {32'h0000_0044, 32'h0000_0099};
      txn(1, 32'h0000_0044, 32'h0000_4444, 0, 1, 1'b1, 1'b0);
      req      = 2'b11;
      req_data = {32'h0000_0002, 32'h0000_0001};
      txn(0, 32'h0000_0001, 32'h0000_5555, 0, 0, 1'b0, 1'b0);
      req = '0;

      // Stray response while IDLE.
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hDEAD_BEEF;
      #1;
      check("stray_resp_valid", 64'(resp_valid), 64'(0));
      check("stray_resp_data", resp_data, 64'(0));
      cyc();
      check("stray_gnt", 64'(gnt), 64'(0));
      check("stray_req_valid", 64'(mem_req_valid), 64'(0));
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;

      // Reset in WAIT, late response ignored, next grant restarts at 0.
      req      = 2'b10;
      req_data = {32'h0000_0066, 32'h0000_0055};
      cyc();
      check("r6_issue_gnt", 64'(gnt), 64'(oh(1)));
      mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0;
      req           = '0;
      check("r6_wait_gnt", 64'(gnt), 64'(oh(1)));
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("r6_rst_gnt", 64'(gnt), 64'(0));
      check("r6_rst_req_valid", 64'(mem_req_valid), 64'(0));
      check("r6_rst_req_data", 64'(mem_req_data), 64'(0));
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h0000_0777;
      #1;
      check("r6_late_resp_valid", 64'(resp_valid), 64'(0));
      check("r6_late_resp_data", resp_data, 64'(0));
      cyc();
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      check("r6_idle_gnt", 64'(gnt), 64'(0));
      req      = 2'b11;
      req_data = {32'h0000_0022, 32'h0000_0011};
      txn(0, 32'h0000_0011, 32'h0000_6666, 0, 0, 1'b0, 1'b0);
      req = '0;

      cyc();
      check("sb_empty", 64'(sb_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
